fifo_wr_ptr_full_ctrl: RTL and testbench
========================================

Name: fifo_wr_ptr_full_ctrl

Overview:
- Write-domain pointer and flag generator for the asynchronous dual-clock FIFO.
- Sits directly upstream of the N-stage pointer synchronizer: its registered Gray write pointer feeds the synchronizer that crosses into the read domain.
- Also consumes the read pointer after it has been synchronized into the write domain, and from it derives full, almost-full, fill count and overflow.
- Drives the RAM write address and the qualified write enable.

Parameters:
- ADDRWIDTH, 3, RAM address width. Depth = 2**ADDRWIDTH. Pointers are ADDRWIDTH+1 bits. Legal range 2..16.
- AFULL_VAL, 6, almost-full threshold in words, 1..2**ADDRWIDTH.

Ports:
- clk  in  1  write-domain clock.
- arstn  in  1  reset, asynchronous, active-low.
- srstn  in  1  synchronous reset, active-low, sampled on clk.
- we  in  1  write request from the user.
- rd_ptr_gray_sync  in  ADDRWIDTH+1  read Gray pointer, already synchronized into clk.
- wr_ptr_gray  out  ADDRWIDTH+1  registered Gray write pointer, to the synchronizer.
- waddr  out  ADDRWIDTH  RAM write address = low ADDRWIDTH bits of the binary pointer.
- wen_mem  out  1  qualified RAM write enable (combinational).
- full  out  1  registered full flag.
- afull  out  1  registered almost-full flag.
- wrcnt  out  ADDRWIDTH+1  registered fill level seen from the write side.
- overflow  out  1  one-cycle registered pulse when a write is rejected.

Behaviour:
- Reset: when arstn=0 (async) or srstn=0 (at clk edge), every register clears: wbin=0, wr_ptr_gray=0, full=0, afull=0, wrcnt=0, overflow=0. srstn has priority over we.
- Write acceptance:
  - wen_mem = we & ~full.
  - An accepted write increments wbin by 1, modulo 2**(ADDRWIDTH+1); the pointer wraps naturally.
  - waddr always reflects the current wbin, so the RAM writes at the pre-increment address.
- Pointer encoding:
  - wbin_next = wbin + wen_mem.
  - wr_ptr_gray <= wbin_next ^ (wbin_next >> 1), registered in the same cycle as wbin.
  - wr_ptr_gray changes at most one bit per clk; required for a safe crossing.
- Read pointer: rbin_sync = Gray-to-binary(rd_ptr_gray_sync), combinational.
- Full:
  - full <= (gray(wbin_next) == {~rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_ptr_gray_sync[ADDRWIDTH-2:0]}).
  - Full asserts the cycle after the write that fills the last location.
  - Full deasserts one clk after the synchronized read pointer advances. Total latency from the read side = sync stages + 1.
- Count and almost-full:
  - wrcnt <= wbin_next - rbin_sync, modulo 2**(ADDRWIDTH+1). Range 0..2**ADDRWIDTH.
  - afull <= (wbin_next - rbin_sync) >= AFULL_VAL.
- Overflow: overflow <= we & full. Pointers are unchanged on a rejected write.
- Simultaneous write and read-pointer update: both are used in the same next-state computation. Example: full with a freeing read and we=1 in the same cycle → the write is still rejected (full was 1), and full re-evaluates against the new pointer.
- Flag conservatism: full and wrcnt may be pessimistic, never optimistic, because the read pointer lags.
- No state machine: a pointer-register datapath with a registered flag stage.

Decomposition:
- Shared fifo package holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - A pointer width constant derived from ADDRWIDTH.
- One natural sub-module: fifo_gray2bin (combinational XOR-prefix converter). The read-side empty controller reuses it.

Test Plan (ADDRWIDTH=3, AFULL_VAL=6):
- Fill: rd_ptr_gray_sync=0, we=1 for 8 cycles.
  - wr_ptr_gray sequence: 1,3,2,6,7,5,4,C.
  - afull rises after the 6th write.
  - full=1 and wrcnt=8 after the 8th write.
  - wen_mem=0 from the next cycle.
- Overflow: while full, we=1 for 1 cycle → overflow=1 for exactly one cycle; waddr stays 0; wr_ptr_gray stays C.
- Drain: full, then set rd_ptr_gray_sync=2 (binary 3) → next cycle full=0, wrcnt=5, afull=0.
- Wrap: keep rd_ptr_gray_sync two entries behind and write 16 words total → wbin wraps to 0, wr_ptr_gray returns to 0, full never asserts, no overflow.
- Synchronous reset:
  - srstn=0 for 1 cycle after 5 writes → all outputs 0 at the next edge.
  - Next write uses waddr=0.
- Asynchronous reset: drop arstn mid-cycle while full → full, wrcnt and wr_ptr_gray clear immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_wr_ptr_full_ctrl_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion.
// The conversion functions work on a fixed maximum width. Callers zero-extend
// narrower pointers and then truncate the result. Leading zero bits do not
// change either transform.
package fifo_wr_ptr_full_ctrl_pkg;

    localparam int MAX_ADDRWIDTH = 16;
    localparam int MAX_PTR_W     = MAX_ADDRWIDTH + 1;

    localparam int ADDRWIDTH_DEF = 3;
    localparam int PTR_W_DEF     = ADDRWIDTH_DEF + 1;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addrwidth);
        return addrwidth + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        for (int i = 0; i < MAX_PTR_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ptr_full_ctrl_if.sv
// Write-side bus of the async FIFO. The user and RAM side is the master.
// The pointer/flag controller is the slave.
interface fifo_wr_ptr_full_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 we;
    logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic [ADDRWIDTH-1:0] waddr;
    logic                 wen_mem;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wrcnt;
    logic                 overflow;

    modport master (
        output we, rd_ptr_gray_sync,
        input  wr_ptr_gray, waddr, wen_mem, full, afull, wrcnt, overflow
    );

    modport slave (
        input  we, rd_ptr_gray_sync,
        output wr_ptr_gray, waddr, wen_mem, full, afull, wrcnt, overflow
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter. Each output bit is the XOR prefix
// of all Gray bits at or above it. This block is shared with the read-side
// empty controller.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the reduction XOR of the Gray bits from its position upward.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_full_ctrl.sv
// Write-domain pointer and flag generator for the dual-clock FIFO.
// The registered Gray pointer feeds the read-domain synchronizer. The
// read pointer arriving from that domain is only used to compute the flags.
// Because that read pointer lags the real one, full and wrcnt can only be
// pessimistic.
module fifo_wr_ptr_full_ctrl
    import fifo_wr_ptr_full_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AFULL_VAL = 6
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   srstn,
    fifo_wr_ptr_full_ctrl_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDRWIDTH);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] rbin_sync;
    logic [PTR_W-1:0] fill_next;
    logic [PTR_W-1:0] full_pattern;
    logic [PTR_W-1:0] gray_q;
    logic [PTR_W-1:0] wrcnt_q;
    logic             wen;
    logic             full_q;
    logic             afull_q;
    logic             overflow_q;
    logic             full_next;
    logic             afull_next;

    fifo_gray2bin #(.W(PTR_W)) u_rd_gray2bin (
        .gray (bus.rd_ptr_gray_sync),
        .bin  (rbin_sync)
    );

    // Qualify the write and form the next pointer plus all next-state flags.
    // full_pattern is the synchronized read pointer with its top two Gray bits
    // inverted. That value is the Gray write pointer exactly one depth ahead.
    always_comb begin
        wen          = bus.we & ~full_q;
        wbin_next    = wbin + {{(PTR_W-1){1'b0}}, wen};
        gray_next    = PTR_W'(bin2gray(MAX_PTR_W'(wbin_next)));
        full_pattern = {~bus.rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1],
                        bus.rd_ptr_gray_sync[ADDRWIDTH-2:0]};
        full_next    = (gray_next == full_pattern);
        fill_next    = wbin_next - rbin_sync;
        afull_next   = (fill_next >= PTR_W'(AFULL_VAL));
    end

    // Pointer and flag registers. The synchronous clear wins over a pending write.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wbin       <= '0;
            gray_q     <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            wrcnt_q    <= '0;
            overflow_q <= 1'b0;
        end else if (!srstn) begin
            wbin       <= '0;
            gray_q     <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            wrcnt_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            gray_q     <= gray_next;
            full_q     <= full_next;
            afull_q    <= afull_next;
            wrcnt_q    <= fill_next;
            overflow_q <= bus.we & full_q;
        end
    end

    assign bus.wen_mem     = wen;
    assign bus.waddr       = wbin[ADDRWIDTH-1:0];
    assign bus.wr_ptr_gray = gray_q;
    assign bus.full        = full_q;
    assign bus.afull       = afull_q;
    assign bus.wrcnt       = wrcnt_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full_ctrl.sv
// Directed bench for the FIFO write-side pointer/flag controller (ADDRWIDTH=3, AFULL_VAL=6).
module tb_fifo_wr_ptr_full_ctrl;

    typedef struct {
        logic       srstn;
        logic       we;
        logic [3:0] rd;
        logic       exp_wen;
        logic [3:0] exp_gray;
        logic [2:0] exp_waddr;
        logic       exp_full;
        logic       exp_afull;
        logic [3:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    logic clk;
    logic arstn;
    logic srstn;
    int   n_checks;
    int   n_errors;

    fifo_wr_ptr_full_ctrl_if #(.ADDRWIDTH(3)) bus ();

    fifo_wr_ptr_full_ctrl #(.ADDRWIDTH(3), .AFULL_VAL(6)) dut (
        .clk   (clk),
        .arstn (arstn),
        .srstn (srstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] g(input int b);
        int m;
        m = b & 15;
        return 4'((m ^ (m >> 1)) & 15);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        srstn                = v.srstn;
        bus.we               = v.we;
        bus.rd_ptr_gray_sync = v.rd;
        #1;
        chk({nm, ".wen_mem"}, 32'(bus.wen_mem), 32'(v.exp_wen));
        @(posedge clk);
        #1;
        chk({nm, ".wr_ptr_gray"}, 32'(bus.wr_ptr_gray), 32'(v.exp_gray));
        chk({nm, ".waddr"},       32'(bus.waddr),       32'(v.exp_waddr));
        chk({nm, ".full"},        32'(bus.full),        32'(v.exp_full));
        chk({nm, ".afull"},       32'(bus.afull),       32'(v.exp_afull));
        chk({nm, ".wrcnt"},       32'(bus.wrcnt),       32'(v.exp_cnt));
        chk({nm, ".overflow"},    32'(bus.overflow),    32'(v.exp_ovf));
    endtask

    vec_t tbl[13];

    initial begin
        vec_t       v;
        logic [3:0] prev_gray;
        int         rb;
        int         cnt;

        n_checks = 0;
        n_errors = 0;

        // srstn we rd | wen gray waddr full afull cnt ovf
        tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h2, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h6, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h7, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h5, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0};
        // rejected write while full
        tbl[8]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0};
        // read pointer advances to binary 3
        tbl[10] = '{1'b1, 1'b0, 4'h2, 1'b0, 4'hC, 3'd0, 1'b0, 1'b0, 4'd5, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'h2, 1'b1, 4'hD, 3'd1, 1'b0, 1'b1, 4'd6, 1'b0};
        // sync reset beats a concurrent write
        tbl[12] = '{1'b0, 1'b1, 4'h2, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};

        arstn                = 1'b0;
        srstn                = 1'b1;
        bus.we               = 1'b0;
        bus.rd_ptr_gray_sync = 4'h0;
        #2;
        chk("reset.wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'h0);
        chk("reset.waddr",       32'(bus.waddr),       32'h0);
        chk("reset.full",        32'(bus.full),        32'h0);
        chk("reset.afull",       32'(bus.afull),       32'h0);
        chk("reset.wrcnt",       32'(bus.wrcnt),       32'h0);
        chk("reset.overflow",    32'(bus.overflow),    32'h0);
        chk("reset.wen_mem",     32'(bus.wen_mem),     32'h0);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Wrap: the read pointer trails two entries, 16 writes bring wbin back to 0
        prev_gray = 4'h0;
        for (int k = 0; k < 16; k++) begin
            rb  = (k < 2) ? 0 : k - 2;
            cnt = (k + 1) - rb;
            v   = '{1'b1, 1'b1, g(rb), 1'b1, g(k + 1), 3'((k + 1) & 7),
                    1'b0, (cnt >= 6), 4'(cnt), 1'b0};
            apply(v, $sformatf("wrap%0d", k));
            chk($sformatf("wrap%0d.gray_onebit", k),
                32'($countones(bus.wr_ptr_gray ^ prev_gray)), 32'd1);
            prev_gray = bus.wr_ptr_gray;
        end
        chk("wrap.final_gray", 32'(bus.wr_ptr_gray), 32'h0);

        // Sync reset after 5 writes, then the next write starts at address 0
        v = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        apply(v, "sr_clear");
        for (int k = 0; k < 5; k++) begin
            v = '{1'b1, 1'b1, 4'h0, 1'b1, g(k + 1), 3'(k + 1), 1'b0, 1'b0, 4'(k + 1), 1'b0};
            apply(v, $sformatf("sr_wr%0d", k));
        end
        v = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        apply(v, "sr_pulse");
        @(negedge clk);
        srstn  = 1'b1;
        bus.we = 1'b1;
        #1;
        chk("sr_after.waddr_pre", 32'(bus.waddr), 32'h0);
        chk("sr_after.wen_mem",   32'(bus.wen_mem), 32'h1);
        @(posedge clk);
        #1;
        chk("sr_after.wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'h1);
        chk("sr_after.wrcnt",       32'(bus.wrcnt),       32'h1);

        // Fill to full from wbin=1, then drop arstn between clock edges
        for (int k = 0; k < 7; k++) begin
            v = '{1'b1, 1'b1, 4'h0, 1'b1, g(k + 2), 3'((k + 2) & 7),
                  (k + 2 == 8), (k + 2 >= 6), 4'(k + 2), 1'b0};
            apply(v, $sformatf("ar_fill%0d", k));
        end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        chk("ar.full_before", 32'(bus.full), 32'h1);
        arstn = 1'b0;
        #1;
        chk("ar.full",        32'(bus.full),        32'h0);
        chk("ar.wrcnt",       32'(bus.wrcnt),       32'h0);
        chk("ar.wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'h0);
        chk("ar.no_edge",     32'(clk),             32'h0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
